// File: rtl/vga_sync_generator.sv
// VGA 640x480@60 timing: divided pixel enable, pixel counters, zero-skew registered syncs.
// Define VGA_FRAME_TICK_EN to add a one-clock frame_tick strobe on the end-of-frame wrap.
module vga_sync_generator #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_cnt;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       line_end;

  assign line_end = p_tick && (h_cnt == H_LAST);

  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (p_tick) begin
      h_next = line_end ? 10'd0 : h_cnt + 10'd1;
    end
    if (line_end) begin
      v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Syncs are decoded from the next counter values so they change on the same edge as the pixel position.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= 4'd0;
      p_tick  <= 1'b0;
      h_cnt   <= 10'd0;
      v_cnt   <= 10'd0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
      p_tick  <= (div_cnt == DIV_LAST);
      h_cnt   <= h_next;
      v_cnt   <= v_next;
      hsync   <= !((h_next >= HS_START) && (h_next <= HS_END));
      vsync   <= !((v_next >= VS_START) && (v_next <= VS_END));
    end
  end

`ifdef VGA_FRAME_TICK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= line_end && (v_cnt == V_LAST);
    end
  end
`endif

  assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign pixel_x  = h_cnt;
  assign pixel_y  = v_cnt;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: a full-size instance and a shrunken-timing instance, both checked every cycle
// against a closed-form model that derives all outputs from the number of clocks since reset release.
module tb_vga_sync_generator;

  localparam int A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VD = 480, A_VF = 10, A_VS = 2, A_VB = 33, A_D = 4;
  localparam int B_HD = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VD = 6, B_VF = 1, B_VS = 2, B_VB = 1, B_D = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       a_hs, a_vs, a_vo, a_pt;
  logic       b_hs, b_vs, b_vo, b_pt;
  logic [9:0] a_x, a_y, b_x, b_y;
`ifdef VGA_FRAME_TICK_EN
  logic       a_ft, b_ft;
`endif

  int total = 0;
  int bad   = 0;
  int k_a   = 0;
  int k_b   = 0;
  bit va    = 1'b0;
  bit vb    = 1'b0;

  vga_sync_generator dut_a (
    .clk(clk), .rst(rst_a), .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .p_tick(a_pt),
`ifdef VGA_FRAME_TICK_EN
    .frame_tick(a_ft),
`endif
    .pixel_x(a_x), .pixel_y(a_y)
  );

  vga_sync_generator #(
    .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB), .CLK_DIV(B_D)
  ) dut_b (
    .clk(clk), .rst(rst_b), .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .p_tick(b_pt),
`ifdef VGA_FRAME_TICK_EN
    .frame_tick(b_ft),
`endif
    .pixel_x(b_x), .pixel_y(b_y)
  );

  // Clocks elapsed since the last edge that sampled reset high.
  always @(posedge clk) begin
    if (rst_a) begin k_a <= 0; va <= 1'b1; end
    else if (va) k_a <= k_a + 1;
    if (rst_b) begin k_b <= 0; vb <= 1'b1; end
    else if (vb) k_b <= k_b + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel advances happen on edges k = 1+D, 1+2D, ...; everything else follows from the pixel index.
  task automatic compareDut(input string tag, input int k, input int d,
                            input int hd, input int hf, input int hs, input int hb,
                            input int vd, input int vf, input int vs, input int vb,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic hsy, input logic vsy, input logic vo, input logic pt);
    int ht, vt, n, p, ex, ey;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    n  = (k == 0) ? 0 : (k - 1) / d;
    p  = n % (ht * vt);
    ex = p % ht;
    ey = p / ht;
    checkOutput({tag, "_pixel_x"}, 32'(x), ex);
    checkOutput({tag, "_pixel_y"}, 32'(y), ey);
    checkOutput({tag, "_hsync"}, 32'(hsy), (ex >= hd + hf && ex < hd + hf + hs) ? 0 : 1);
    checkOutput({tag, "_vsync"}, 32'(vsy), (ey >= vd + vf && ey < vd + vf + vs) ? 0 : 1);
    checkOutput({tag, "_video_on"}, 32'(vo), (ex < hd && ey < vd) ? 1 : 0);
    checkOutput({tag, "_p_tick"}, 32'(pt), (k > 0 && k % d == 0) ? 1 : 0);
  endtask

  function automatic int expFrameTick(input int k, input int d, input int frame_pixels);
    if (k > 1 && (k - 1) % d == 0 && ((k - 1) / d) % frame_pixels == 0) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (va) begin
      compareDut("a", k_a, A_D, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB,
                 a_x, a_y, a_hs, a_vs, a_vo, a_pt);
`ifdef VGA_FRAME_TICK_EN
      checkOutput("a_frame_tick", 32'(a_ft), expFrameTick(k_a, A_D, 800 * 525));
`endif
    end
    if (vb) begin
      compareDut("b", k_b, B_D, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB,
                 b_x, b_y, b_hs, b_vs, b_vo, b_pt);
`ifdef VGA_FRAME_TICK_EN
      checkOutput("b_frame_tick", 32'(b_ft), expFrameTick(k_b, B_D, 15 * 10));
`endif
    end
  end

  // Holds the selected reset high for the given number of clock edges, then releases it just after an edge.
  task automatic applyStimulus(input bit sel_b, input int cycles);
    if (sel_b) rst_b = 1'b1; else rst_a = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    if (sel_b) rst_b = 1'b0; else rst_a = 1'b0;
  endtask

  task automatic runA();
    int low_clks = 0;
    applyStimulus(1'b0, 3);
    @(negedge clk);
    checkOutput("a_reset_x", 32'(a_x), 0);
    checkOutput("a_reset_hsync", 32'(a_hs), 1);
    checkOutput("a_reset_vsync", 32'(a_vs), 1);
    checkOutput("a_reset_video_on", 32'(a_vo), 1);
    checkOutput("a_reset_p_tick", 32'(a_pt), 0);
    while (k_a < 4401) begin
      @(negedge clk);
      if (k_a >= 1 && k_a <= 3200 && a_hs === 1'b0) low_clks++;
      if (k_a == 3)    checkOutput("a_first_tick_early", 32'(a_pt), 0);
      if (k_a == 4)    checkOutput("a_first_tick", 32'(a_pt), 1);
      if (k_a == 8)    checkOutput("a_second_tick", 32'(a_pt), 1);
      if (k_a == 5)    checkOutput("a_x_after_tick", 32'(a_x), 1);
      if (k_a == 2560) checkOutput("a_vo_639", 32'(a_vo), 1);
      if (k_a == 2561) checkOutput("a_vo_640", 32'(a_vo), 0);
      if (k_a == 2624) checkOutput("a_hsync_655", 32'(a_hs), 1);
      if (k_a == 2625) checkOutput("a_hsync_656", 32'(a_hs), 0);
      if (k_a == 3008) checkOutput("a_hsync_751", 32'(a_hs), 0);
      if (k_a == 3009) checkOutput("a_hsync_752", 32'(a_hs), 1);
      if (k_a == 3200) checkOutput("a_x_799", 32'(a_x), 799);
      if (k_a == 3201) checkOutput("a_x_wrap", 32'(a_x), 0);
      if (k_a == 3201) checkOutput("a_y_wrap", 32'(a_y), 1);
    end
    checkOutput("a_hsync_low_clks", 32'(low_clks), 384);
    checkOutput("a_mid_x", 32'(a_x), 300);
    applyStimulus(1'b0, 1);
    @(negedge clk);
    checkOutput("a_midrst_x", 32'(a_x), 0);
    checkOutput("a_midrst_y", 32'(a_y), 0);
    checkOutput("a_midrst_p_tick", 32'(a_pt), 0);
    while (k_a < 4) @(negedge clk);
    checkOutput("a_restart_tick", 32'(a_pt), 1);
    repeat (3) begin
      repeat ($urandom_range(200, 1500)) @(negedge clk);
      applyStimulus(1'b0, $urandom_range(1, 5));
    end
    repeat (1000) @(negedge clk);
  endtask

  task automatic runB();
    int ticks = 0;
    applyStimulus(1'b1, 3);
    while (k_b < 901) begin
      @(negedge clk);
`ifdef VGA_FRAME_TICK_EN
      if (b_ft === 1'b1) ticks++;
      if (k_b == 451) checkOutput("b_frame_tick_wrap", 32'(b_ft), 1);
`endif
      if (k_b == 315) checkOutput("b_vsync_y6", 32'(b_vs), 1);
      if (k_b == 316) checkOutput("b_vsync_y7", 32'(b_vs), 0);
      if (k_b == 450) checkOutput("b_x_last", 32'(b_x), 14);
      if (k_b == 450) checkOutput("b_y_last", 32'(b_y), 9);
      if (k_b == 451) checkOutput("b_x_wrap", 32'(b_x), 0);
      if (k_b == 451) checkOutput("b_y_wrap", 32'(b_y), 0);
    end
`ifdef VGA_FRAME_TICK_EN
    checkOutput("b_frame_tick_count", 32'(ticks), 2);
`endif
    while (k_b < 1096) @(negedge clk);
    checkOutput("b_mid_x", 32'(b_x), 5);
    checkOutput("b_mid_y", 32'(b_y), 4);
    applyStimulus(1'b1, 1);
    @(negedge clk);
    checkOutput("b_midrst_x", 32'(b_x), 0);
    checkOutput("b_midrst_y", 32'(b_y), 0);
    checkOutput("b_midrst_hsync", 32'(b_hs), 1);
    repeat (20) begin
      repeat ($urandom_range(50, 600)) @(negedge clk);
      applyStimulus(1'b1, $urandom_range(1, 4));
    end
    repeat (500) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      runA();
      runB();
    join
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
